// File: rtl/axi_lite_ram_strb.sv
// AXI4-Lite slave RAM with byte strobes, independent AW/W holding registers,
// SLVERR for out-of-range addresses and a fixed, backpressure-safe read latency.
module axi_lite_ram_strb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awready,
  input  logic                    wvalid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wready,
  output logic                    bvalid,
  output logic [1:0]              bresp,
  input  logic                    bready,
  input  logic                    arvalid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arready,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  input  logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0] LAT_M1      = 2'(RD_LATENCY - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  r_en;
  logic                  r_aw_full;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_w_full;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTES-1:0]      r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic                  r_rd_busy;
  logic [1:0]            r_rd_cnt;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic [ADDR_WIDTH-1:0] w_wr_word;
  logic [ADDR_WIDTH-1:0] w_rd_word;
  logic                  w_wr_inrange;
  logic                  w_rd_inrange;
  logic [IDXW-1:0]       w_wr_idx;
  logic [IDXW-1:0]       w_rd_idx;
  logic                  w_commit;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;

  assign w_wr_word    = r_awaddr >> OFFS;
  assign w_rd_word    = araddr >> OFFS;
  assign w_wr_inrange = (w_wr_word < DEPTH_A);
  assign w_rd_inrange = (w_rd_word < DEPTH_A);
  assign w_wr_idx     = w_wr_word[IDXW-1:0];
  assign w_rd_idx     = w_rd_word[IDXW-1:0];
  assign w_commit     = r_aw_full && r_w_full;

  // r_en holds the readies low until the first edge after reset release
  assign awready = r_en && !r_aw_full && !r_bvalid;
  assign wready  = r_en && !r_w_full && !r_bvalid;
  assign arready = r_en && !r_rd_busy && !r_rvalid;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;

  assign bvalid = r_bvalid;
  assign bresp  = r_bresp;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign rresp  = r_rresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_aw_full <= 1'b0;
      r_awaddr  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_en <= 1'b1;
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      // Both buffers full means neither ready is up, so no handshake can collide here
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_inrange ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_wr_inrange) begin
      for (int i = 0; i < BYTES; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_wr_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  // Data is captured at the AR edge (old contents on a same-edge commit) and held until R completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_busy <= 1'b0;
      r_rd_cnt  <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_rd_busy <= 1'b1;
        r_rd_cnt  <= LAT_M1;
        r_rdata   <= w_rd_inrange ? r_mem[w_rd_idx] : '0;
        r_rresp   <= w_rd_inrange ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rd_busy) begin
        if (r_rd_cnt == 2'd0) begin
          r_rd_busy <= 1'b0;
          r_rvalid  <= 1'b1;
        end else begin
          r_rd_cnt <= r_rd_cnt - 2'd1;
        end
      end
      if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_strb.sv
// Randomised bench for axi_lite_ram_strb: a transaction-level model of the RAM
// and its channel rules is compared against the DUT outputs every cycle.
module tb_axi_lite_ram_strb;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic          clk;
  logic          rst;
  logic          awvalid;
  logic [AW-1:0] awaddr;
  logic          awready;
  logic          wvalid;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wready;
  logic          bvalid;
  logic [1:0]    bresp;
  logic          bready;
  logic          arvalid;
  logic [AW-1:0] araddr;
  logic          arready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rready;

  int total = 0;
  int bad   = 0;

  axi_lite_ram_strb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Reference model: memory with per-byte "known" mask plus channel bookkeeping
  logic [31:0] mMem [DEPTH];
  bit   [3:0]  mKnown [DEPTH];
  bit          mEn, mAwHave, mWHave, mBOut, mROut, mRKnown;
  logic [31:0] mAwAddr, mWData, mRData;
  logic [3:0]  mWStrb;
  logic [1:0]  mBResp, mRResp;
  int          mRdWait;

  function automatic bit inRange(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  task automatic modelStep();
    bit awRdy, wRdy, arRdy;
    int idx;
    if (rst) begin
      mEn = 0; mAwHave = 0; mWHave = 0; mBOut = 0; mROut = 0; mRKnown = 1;
      mBResp = 2'b00; mRResp = 2'b00; mRData = '0; mRdWait = 0;
      return;
    end
    awRdy = mEn && !mAwHave && !mBOut;
    wRdy  = mEn && !mWHave && !mBOut;
    arRdy = mEn && (mRdWait == 0) && !mROut;
    if (mROut && rready) mROut = 0;
    if (mRdWait > 0) begin
      mRdWait--;
      if (mRdWait == 0) mROut = 1;
    end
    if (arvalid && arRdy) begin
      if (inRange(araddr)) begin
        idx = int'(araddr >> 2);
        mRData = mMem[idx]; mRKnown = (mKnown[idx] == 4'hF); mRResp = 2'b00;
      end else begin
        mRData = '0; mRKnown = 1; mRResp = 2'b10;
      end
      mRdWait = LAT;
    end
    if (mBOut && bready) mBOut = 0;
    if (mAwHave && mWHave) begin
      if (inRange(mAwAddr)) begin
        idx = int'(mAwAddr >> 2);
        for (int b = 0; b < 4; b++) begin
          if (mWStrb[b]) begin
            mMem[idx][8*b +: 8] = mWData[8*b +: 8];
            mKnown[idx][b] = 1'b1;
          end
        end
        mBResp = 2'b00;
      end else begin
        mBResp = 2'b10;
      end
      mAwHave = 0; mWHave = 0; mBOut = 1;
    end
    if (awvalid && awRdy) begin mAwHave = 1; mAwAddr = awaddr; end
    if (wvalid && wRdy) begin mWHave = 1; mWData = wdata; mWStrb = wstrb; end
    mEn = 1;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (rst) begin
      checkOutput("rst_awready", 64'(awready), 64'(0));
      checkOutput("rst_wready", 64'(wready), 64'(0));
      checkOutput("rst_arready", 64'(arready), 64'(0));
      checkOutput("rst_bvalid", 64'(bvalid), 64'(0));
      checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
      checkOutput("rst_bresp", 64'(bresp), 64'(0));
      checkOutput("rst_rresp", 64'(rresp), 64'(0));
      checkOutput("rst_rdata", 64'(rdata), 64'(0));
    end else begin
      checkOutput("awready", 64'(awready), 64'(mEn && !mAwHave && !mBOut));
      checkOutput("wready", 64'(wready), 64'(mEn && !mWHave && !mBOut));
      checkOutput("arready", 64'(arready), 64'(mEn && (mRdWait == 0) && !mROut));
      checkOutput("bvalid", 64'(bvalid), 64'(mBOut));
      checkOutput("rvalid", 64'(rvalid), 64'(mROut));
      if (mBOut) checkOutput("bresp", 64'(bresp), 64'(mBResp));
      if (mROut) checkOutput("rresp", 64'(rresp), 64'(mRResp));
      if (mROut && mRKnown) checkOutput("rdata", 64'(rdata), 64'(mRData));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awDly, input int wDly, input int bDly, output logic [1:0] resp);
    bit awDone = 0;
    bit wDone = 0;
    bit awHs, wHs;
    int cyc = 0;
    resp = 2'bxx;
    while (!(awDone && wDone) && cyc < 40) begin
      awvalid = !awDone && (cyc >= awDly);
      awaddr  = addr;
      wvalid  = !wDone && (cyc >= wDly);
      wdata   = data;
      wstrb   = strb;
      #1;
      awHs = awvalid && awready;
      wHs  = wvalid && wready;
      tick();
      if (awHs) awDone = 1;
      if (wHs) wDone = 1;
      cyc++;
    end
    awvalid = 0;
    wvalid  = 0;
    if (!(awDone && wDone)) begin
      checkOutput("aw_w_timeout", 64'(0), 64'(1));
      return;
    end
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!bvalid) begin
      checkOutput("b_timeout", 64'(0), 64'(1));
      return;
    end
    resp = bresp;
    repeat (bDly) begin
      checkOutput("aw_blocked_by_b", 64'(awready), 64'(0));
      checkOutput("w_blocked_by_b", 64'(wready), 64'(0));
      tick();
    end
    bready = 1;
    tick();
    bready = 0;
    checkOutput("aw_ready_after_b", 64'(awready), 64'(1));
  endtask

  task automatic doRead(input logic [31:0] addr, input int arDly, input int rDly,
                        output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit hs = 0;
    int cyc = 0;
    data = 'x;
    resp = 2'bxx;
    lat  = -1;
    repeat (arDly) tick();
    while (!hs && cyc < 40) begin
      arvalid = 1;
      araddr  = addr;
      #1;
      hs = arready;
      tick();
      cyc++;
    end
    arvalid = 0;
    if (!hs) begin
      checkOutput("ar_timeout", 64'(0), 64'(1));
      return;
    end
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    if (!rvalid) begin
      checkOutput("r_timeout", 64'(0), 64'(1));
      return;
    end
    data = rdata;
    resp = rresp;
    repeat (rDly) begin
      checkOutput("r_hold_rvalid", 64'(rvalid), 64'(1));
      checkOutput("r_hold_arready", 64'(arready), 64'(0));
      tick();
    end
    rready = 1;
    tick();
    rready = 0;
  endtask

  task automatic applyStimulus();
    logic [1:0]  resp, rr;
    logic [31:0] d, a;
    int          lat;
    int          kind;

    // Reset entry and release
    rst = 1; awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 0;
    checkOutput("ready_before_first_edge", 64'(awready), 64'(0));
    tick();
    checkOutput("ready_after_first_edge", 64'(awready && wready && arready), 64'(1));

    // Full-word write then read with latency check
    doWrite(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp);
    checkOutput("t1_bresp", 64'(resp), 64'(2'b00));
    doRead(32'h10, 0, 0, d, rr, lat);
    checkOutput("t1_rdata", 64'(d), 64'(32'hDEADBEEF));
    checkOutput("t1_rresp", 64'(rr), 64'(2'b00));
    checkOutput("t1_latency", 64'(lat), 64'(LAT));

    // AW ahead of W, partial strobe
    doWrite(32'h10, 32'h11223344, 4'b0101, 0, 3, 0, resp);
    checkOutput("t2_bresp", 64'(resp), 64'(2'b00));
    doRead(32'h10, 0, 0, d, rr, lat);
    checkOutput("t2_rdata", 64'(d), 64'(32'hDE22BE44));

    // Out of range write and read, word 0 untouched
    doWrite(32'h0, 32'hCAFEF00D, 4'hF, 1, 0, 0, resp);
    doWrite(32'h400, 32'h12345678, 4'hF, 0, 0, 0, resp);
    checkOutput("t3_bresp", 64'(resp), 64'(2'b10));
    doRead(32'h400, 0, 0, d, rr, lat);
    checkOutput("t3_rdata", 64'(d), 64'(0));
    checkOutput("t3_rresp", 64'(rr), 64'(2'b10));
    doRead(32'h0, 0, 0, d, rr, lat);
    checkOutput("t3_word0", 64'(d), 64'(32'hCAFEF00D));

    // Read backpressure, write response backpressure, zero-strobe no-op
    doRead(32'h12, 0, 5, d, rr, lat);
    checkOutput("t4_rdata", 64'(d), 64'(32'hDE22BE44));
    checkOutput("t4_latency", 64'(lat), 64'(LAT));
    doWrite(32'h8, 32'hA5A5A5A5, 4'hF, 0, 0, 4, resp);
    doWrite(32'h8, 32'hFFFFFFFF, 4'h0, 0, 0, 0, resp);
    checkOutput("t5_nostrb_bresp", 64'(resp), 64'(2'b00));
    doRead(32'h8, 0, 0, d, rr, lat);
    checkOutput("t5_nostrb_rdata", 64'(d), 64'(32'hA5A5A5A5));

    // AR handshake on the commit edge sees the old word
    doWrite(32'h20, 32'h01020304, 4'hF, 0, 0, 0, resp);
    fork
      doWrite(32'h20, 32'hAABBCCDD, 4'hF, 0, 0, 0, resp);
      doRead(32'h20, 1, 0, d, rr, lat);
    join
    checkOutput("collide_old", 64'(d), 64'(32'h01020304));
    doRead(32'h20, 0, 0, d, rr, lat);
    checkOutput("collide_new", 64'(d), 64'(32'hAABBCCDD));

    // Reset with a W buffered and a read in flight
    wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; arvalid = 1; araddr = 32'h10;
    tick();
    wvalid = 0; arvalid = 0;
    tick();
    #2;
    rst = 1;
    #1;
    checkOutput("t6_rvalid_now", 64'(rvalid), 64'(0));
    checkOutput("t6_readies_now", 64'({awready, wready, arready}), 64'(0));
    checkOutput("t6_bvalid_now", 64'(bvalid), 64'(0));
    checkOutput("t6_rdata_now", 64'(rdata), 64'(0));
    tick();
    tick();
    rst = 0;
    tick();
    doRead(32'h10, 0, 0, d, rr, lat);
    checkOutput("t6_after_reset", 64'(d), 64'(32'hDE22BE44));
    doWrite(32'h14, 32'h00000055, 4'hF, 0, 0, 0, resp);
    doRead(32'h14, 0, 0, d, rr, lat);
    checkOutput("t6_fresh_write", 64'(d), 64'(32'h00000055));

    // Random mix of concurrent and lone transactions
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 8) a = {$urandom_range(0, 15), 2'($urandom_range(0, 3))};
      else a = 32'h400 + 32'($urandom_range(0, 4096));
      d = $urandom;
      if (kind == 0) begin
        fork
          doWrite(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp);
          doRead({$urandom_range(0, 15), 2'b00}, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), a, rr, lat);
        join
      end else if (kind == 1) begin
        doWrite(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp);
      end else begin
        doRead(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), d, rr, lat);
        checkOutput("rand_latency", 64'(lat), 64'(LAT));
      end
    end
    repeat (4) tick();
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
